// File: rtl/ram_stream_reader_pkg.sv
// Shared constants and FSM encoding for the RAM stream reader.
package ram_stream_reader_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 8;
    // Cycles from rd_en to valid rd_data.
    localparam int RAM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// Show-ahead FIFO with occupancy output and synchronous flush.
module ram_stream_reader_stream_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = i_pop && !w_empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage array; no reset needed since the output is gated by occupancy.
    always_ff @(posedge i_clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Scans a latency-2 RAM from address 0 upward and streams the words out
// through a credit-limited skid FIFO.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_first,
    output logic              o_out_last
);

    localparam int LAT   = RAM_RD_LATENCY;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = OCC_W + 2;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;          // address of the next read to issue
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic [1:0]        r_rd_tag;       // {last, first} of the read on the RAM port
    logic [LAT-1:0]    r_pipe_vld;
    logic [1:0]        r_pipe_tag [LAT];

    logic [OCC_W-1:0]  w_occ;
    logic [DATA_W+1:0] w_fifo_data;
    logic              w_pop;
    logic              w_push;
    logic [CR_W-1:0]   w_committed;
    logic              w_credit_ok;
    logic              w_issue;
    logic [CNT_W-1:0]  w_issue_idx;
    logic              w_issue_last;
    logic              w_issue_first;

    // Words already owed to the FIFO: stored, on the RAM port, or in the latency pipe.
    always_comb begin
        w_committed = CR_W'(w_occ) + CR_W'(r_rd_en);
        for (int i = 0; i < LAT; i++) begin
            w_committed = w_committed + CR_W'(r_pipe_vld[i]);
        end
    end

    assign w_pop         = o_out_valid && i_out_ready;
    assign w_push        = r_pipe_vld[LAT-1];
    assign w_credit_ok   = (w_committed - CR_W'(w_pop)) < CR_W'(FIFO_DEPTH);
    assign w_issue       = !i_abort && w_credit_ok &&
                           ((r_state == StIssue) || ((r_state == StIdle) && i_start));
    assign w_issue_idx   = (r_state == StIdle) ? '0 : r_cnt;
    assign w_issue_last  = (w_issue_idx == LAST_IDX);
    assign w_issue_first = (w_issue_idx == '0);
    assign o_done        = w_pop && o_out_last && (r_state == StDrain) && !i_abort;

    // Scan FSM, read issue, address counter and RAM latency tracking.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_tag   <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else if (i_abort) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_tag   <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else begin
            r_rd_en       <= w_issue;
            r_pipe_vld[0] <= r_rd_en;
            r_pipe_tag[0] <= r_rd_tag;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            if (w_issue) begin
                r_rd_addr <= w_issue_idx[ADDR_W-1:0];
                r_cnt     <= w_issue_idx + CNT_W'(1);
                r_rd_tag  <= {w_issue_last, w_issue_first};
            end
            case (r_state)
                StIdle: begin
                    if (w_issue) begin
                        r_state <= w_issue_last ? StDrain : StIssue;
                    end
                end
                StIssue: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (o_done) begin
                        r_state   <= StIdle;
                        r_cnt     <= '0;
                        r_rd_addr <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    ram_stream_reader_stream_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (OCC_W)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_abort),
        .i_push      (w_push),
        .i_push_data ({r_pipe_tag[LAT-1], i_rd_data}),
        .i_pop       (w_pop),
        .o_valid     (o_out_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_occ)
    );

    assign o_busy      = (r_state != StIdle);
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_out_data  = w_fifo_data[DATA_W-1:0];
    assign o_out_first = w_fifo_data[DATA_W];
    assign o_out_last  = w_fifo_data[DATA_W+1];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench: DUT plus a 2-cycle-latency RAM model preloaded with mem[i] = i - 128.
module tb_ram_stream_reader;

    localparam int NW = 1024;

    typedef struct {
        int mode;            // 0: always ready, 1: ready 1-in-3 random, 2: not ready for 50 cycles
        int start_again;     // cycle of a second start pulse, -1 for none
        int exp_first_rd;
        int exp_last_rd;     // -1: not checked
        int exp_first_valid;
        int exp_done;        // -1: not checked
        int exp_hold_pulses; // -1: not checked
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic       busy, done, rd_en, valid, first, last;
    logic [9:0] rd_addr;
    logic [7:0] rd_data, data;

    ram_stream_reader #(
        .ADDR_W     (10),
        .DATA_W     (8),
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_out_valid (valid),
        .i_out_ready (ready),
        .o_out_data  (data),
        .o_out_first (first),
        .o_out_last  (last)
    );

    always #5 clk = ~clk;

    // RAM model: data_out updates two cycles after rd_en and holds otherwise.
    logic [7:0] mem [NW];
    logic [7:0] ram_s1 = 8'd0;
    logic [7:0] ram_dout = 8'd0;
    logic       ram_v = 1'b0;
    always @(posedge clk) begin
        ram_v <= rd_en;
        if (rd_en) ram_s1 <= mem[rd_addr];
        if (ram_v) ram_dout <= ram_s1;
    end
    assign rd_data = ram_dout;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [9:0] q[$];
    int c0 = 0;
    int rd_cnt, popped, first_rd, last_rd, first_valid, done_cyc, done_cnt;
    bit mon_en = 1'b0;
    vec_t vecs[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_word(input int i);
        logic [7:0] w;
        w = 8'(i - 128);
        return {(i == NW - 1), (i == 0), w};
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return ($urandom_range(0, 2) == 0);
            2:       return (k >= 50);
            default: return 1'b1;
        endcase
    endfunction

    task automatic prep();
        rd_cnt = 0; popped = 0; first_rd = -1; last_rd = -1;
        first_valid = -1; done_cyc = -1; done_cnt = 0;
        q.delete();
        for (int i = 0; i < NW; i++) q.push_back(exp_word(i));
    endtask

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (rd_en) begin
                chk("rd_addr", int'(rd_addr), rd_cnt % NW);
                if (rd_cnt == 0) first_rd = cyc - c0;
                last_rd = cyc - c0;
                rd_cnt++;
                if (rd_cnt - popped > 4) chk("credit_committed", rd_cnt - popped, 4);
            end
            if (valid && first_valid < 0) first_valid = cyc - c0;
            if (valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", int'({last, first, data}), -1);
                end else begin
                    chk("stream_word", int'({last, first, data}), int'(q[0]));
                    if (ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - c0;
                chk("done_with_last", int'(valid && ready && last), 1);
            end
        end
    end

    task automatic run_scan(input vec_t v);
        int hold_pulses;
        int k;
        hold_pulses = -1;
        prep();
        mon_en = 1'b1;
        @(posedge clk); #1;
        c0 = cyc; start = 1'b1; ready = ready_for(v.mode, 0);
        while (done_cyc < 0 && (cyc - c0) < 8000) begin
            @(posedge clk); #1;
            k = cyc - c0;
            start = (k == v.start_again);
            if (k == 50) hold_pulses = rd_cnt;
            ready = ready_for(v.mode, k);
        end
        start = 1'b0; ready = 1'b0;
        chk("done_seen", int'(done_cyc >= 0), 1);
        chk("busy_after_done", int'(busy), 0);
        chk("rd_addr_after_done", int'(rd_addr), 0);
        chk("words_accepted", popped, NW);
        chk("reads_issued", rd_cnt, NW);
        chk("done_pulses", done_cnt, 1);
        chk("scoreboard_empty", q.size(), 0);
        chk("first_rd_cycle", first_rd, v.exp_first_rd);
        chk("first_valid_cycle", first_valid, v.exp_first_valid);
        if (v.exp_last_rd >= 0) chk("last_rd_cycle", last_rd, v.exp_last_rd);
        if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
        if (v.exp_hold_pulses >= 0) chk("rd_pulses_while_stalled", hold_pulses, v.exp_hold_pulses);
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 500, 1, 1024, 4, 1027, -1};
        vecs[1] = '{1, -1, 1, -1, 4, -1, -1};
        vecs[2] = '{2, -1, 1, -1, 4, -1, 4};
        for (int i = 0; i < NW; i++) mem[i] = 8'(i - 128);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy, done, rd_en, rd_addr, valid, data, first, last}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_scan(vecs[i]);

        // Abort when word 100 is at the head of the stream.
        prep();
        mon_en = 1'b1;
        @(posedge clk); #1;
        c0 = cyc; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (popped < 100 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_word100", popped, 100);
        ready = 1'b0; abort = 1'b1; mon_en = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", int'(valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        q.delete(); rd_cnt = 0; mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_reads", rd_cnt, 0);
        run_scan(vecs[0]);

        // Reset pulse in the middle of a scan.
        prep();
        mon_en = 1'b1;
        @(posedge clk); #1;
        c0 = cyc; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_scan", int'({busy, done, rd_en, rd_addr, valid, data, first, last}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        run_scan(vecs[0]);

        // start together with abort while idle.
        prep();
        q.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        c0 = cyc; start = 1'b1; abort = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_rd_en", int'(rd_en), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("start_abort_no_reads", rd_cnt, 0);
        chk("start_abort_no_valid", first_valid, -1);
        ready = 1'b0;
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
